// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed 7-segment display driver. Scans N_DIGITS digits over a
//   shared a-g segment bus, one digit per slot of SCAN_DIV cycles. Each slot
//   opens with DEAD dark cycles to suppress ghosting. Digit codes are
//   double-buffered: the shadow buffer is loaded at any time, and the active
//   buffer copies it only at the frame boundary, so a frame never shows a mix
//   of old and new codes.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable; 0 freezes the counters and blanks the outputs
//   load       in   capture codes into the shadow buffer this cycle
//   codes      in   5*N_DIGITS; digit k code at [5k+4:5k]
//   seg        out  {a,b,c,d,e,f,g}, bit6 = a (inverted when ACTIVE_LOW)
//   dig_sel    out  one-hot digit select, bit k = digit k (inverted when ACTIVE_LOW)
//   frame_done out  one-cycle pulse after each frame boundary (never inverted)
module seg7_scan_driver #(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEAD       = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [5*N_DIGITS-1:0]   codes,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     dig_sel,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_DIGITS-1:0][4:0]  shadow_q, shadow_d;
    logic [N_DIGITS-1:0][4:0]  active_q, active_d;
    logic [6:0]                seg_q, seg_d;
    logic [N_DIGITS-1:0]       dig_q, dig_d;
    logic                      frame_done_q, frame_done_d;
    logic                      boundary;
    logic                      lit;

    // Active-high segment pattern for a 5-bit digit code.
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'h00:   g = 7'h7E;
            5'h01:   g = 7'h30;
            5'h02:   g = 7'h6D;
            5'h03:   g = 7'h79;
            5'h04:   g = 7'h33;
            5'h05:   g = 7'h5B;
            5'h06:   g = 7'h5F;
            5'h07:   g = 7'h70;
            5'h08:   g = 7'h7F;
            5'h09:   g = 7'h7B;
            5'h0A:   g = 7'h77;
            5'h0B:   g = 7'h1F;
            5'h0C:   g = 7'h4E;
            5'h0D:   g = 7'h3D;
            5'h0E:   g = 7'h4F;
            5'h0F:   g = 7'h47;
            5'h11:   g = 7'h01;   // '-'
            default: g = 7'h00;   // 0x10 and 0x12-0x1F are blank
        endcase
        return g;
    endfunction

    always_comb begin
        boundary = en && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        lit      = en && (int'(cnt_q) >= DEAD);

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Active copies the shadow as it was before this cycle's load, so a
        // load on the boundary cycle itself shows up one frame later.
        shadow_d = load ? codes : shadow_q;
        active_d = boundary ? shadow_q : active_q;

        // Outputs reflect the pre-edge counter state, giving one cycle of lag.
        seg_d = '0;
        dig_d = '0;
        if (lit) begin
            dig_d[idx_q] = 1'b1;
            seg_d        = glyph(active_q[idx_q]);
        end

        frame_done_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            seg_q        <= '0;
            dig_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pin polarity applied after the registers; idle therefore reads as all
    // ones on an active-low board.
    assign seg        = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dig_sel    = (ACTIVE_LOW != 0) ? ~dig_q : dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, SCAN_DIV=4, DEAD=1.
// Two instances share all inputs: one active-high, one ACTIVE_LOW.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [19:0] codes;
    logic [6:0]  seg,     seg_al;
    logic [3:0]  dig_sel, dig_sel_al;
    logic        frame_done, frame_done_al;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .DEAD(1), .ACTIVE_LOW(0)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .codes      (codes),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .DEAD(1), .ACTIVE_LOW(1)) u_dut_al (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .codes      (codes),
        .seg        (seg_al),
        .dig_sel    (dig_sel_al),
        .frame_done (frame_done_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare both instances against one active-high expectation.
    task automatic chk_outs(input string tag, input logic [3:0] d, input logic [6:0] s, input logic f);
        logic [3:0] nd;
        logic [6:0] ns;
        nd = ~d;
        ns = ~s;
        chk({tag, " dig"},    32'(dig_sel),       32'(d));
        chk({tag, " seg"},    32'(seg),           32'(s));
        chk({tag, " fd"},     32'(frame_done),    32'(f));
        chk({tag, " al_dig"}, 32'(dig_sel_al),    32'(nd));
        chk({tag, " al_seg"}, 32'(seg_al),        32'(ns));
        chk({tag, " al_fd"},  32'(frame_done_al), 32'(f));
    endtask

    task automatic expect_edge(input string tag, input logic [3:0] d, input logic [6:0] s, input logic f);
        @(posedge clk);
        #1;
        chk_outs(tag, d, s, f);
    endtask

    // One 16-edge frame: each slot is one dark edge then three lit edges;
    // frame_done is seen after the 16th edge. Optionally pulses load after
    // edge load_at.
    task automatic run_frame(input string tag,
                             input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3,
                             input int load_at, input logic [19:0] new_codes);
        logic [6:0] g [4];
        g = '{g0, g1, g2, g3};
        for (int e = 1; e <= 16; e++) begin
            int slot;
            int ph;
            logic [3:0] d;
            logic [6:0] s;
            slot = (e - 1) / 4;
            ph   = (e - 1) % 4;
            if (ph == 0) begin
                d = 4'b0000;
                s = 7'h00;
            end else begin
                d = 4'b0001 << slot;
                s = g[slot];
            end
            expect_edge($sformatf("%s e%0d", tag, e), d, s, (e == 16));
            if (e == load_at) begin
                load  = 1'b1;
                codes = new_codes;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        codes = '0;

        // Reset held with the clock running.
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset hold", 4'b0000, 7'h00, 1'b0);

        // Release between edges, enable and load {3,2,1,0} together.
        rst_n = 1'b1;
        en    = 1'b1;
        load  = 1'b1;
        codes = {5'd3, 5'd2, 5'd1, 5'd0};

        // First frame still shows the cleared active buffer (code 0).
        run_frame("frame1", 7'h7E, 7'h7E, 7'h7E, 7'h7E, -1, 20'h0);

        // New codes visible; load glyph extremes in slot 2.
        run_frame("frame2", 7'h7E, 7'h30, 7'h6D, 7'h79, 9,
                  {5'h0A, 5'h1F, 5'h11, 5'h10});

        // Extremes visible; load on the boundary cycle itself.
        run_frame("frame3", 7'h00, 7'h01, 7'h00, 7'h77, 15,
                  {5'h0F, 5'h0E, 5'h0D, 5'h01});

        // Boundary load deferred by one frame.
        run_frame("frame4", 7'h00, 7'h01, 7'h00, 7'h77, -1, 20'h0);

        // Digit 0 shows code 1: active-low pins read seg=4F, dig_sel=1110.
        run_frame("frame5", 7'h30, 7'h3D, 7'h4F, 7'h47, -1, 20'h0);

        // Enable pause at cnt=2 of digit 1.
        expect_edge("pause e1", 4'b0000, 7'h00, 1'b0);
        expect_edge("pause e2", 4'b0001, 7'h30, 1'b0);
        expect_edge("pause e3", 4'b0001, 7'h30, 1'b0);
        expect_edge("pause e4", 4'b0001, 7'h30, 1'b0);
        expect_edge("pause e5", 4'b0000, 7'h00, 1'b0);
        expect_edge("pause e6", 4'b0010, 7'h3D, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++)
            expect_edge($sformatf("pause idle%0d", i), 4'b0000, 7'h00, 1'b0);
        en = 1'b1;
        expect_edge("resume d1a", 4'b0010, 7'h3D, 1'b0);
        expect_edge("resume d1b", 4'b0010, 7'h3D, 1'b0);
        expect_edge("resume dead2", 4'b0000, 7'h00, 1'b0);
        expect_edge("resume d2a", 4'b0100, 7'h4F, 1'b0);
        expect_edge("resume d2b", 4'b0100, 7'h4F, 1'b0);
        expect_edge("resume d2c", 4'b0100, 7'h4F, 1'b0);
        expect_edge("resume dead3", 4'b0000, 7'h00, 1'b0);
        expect_edge("resume d3a", 4'b1000, 7'h47, 1'b0);
        expect_edge("resume d3b", 4'b1000, 7'h47, 1'b0);
        expect_edge("resume d3c", 4'b1000, 7'h47, 1'b1);
        expect_edge("next dead0", 4'b0000, 7'h00, 1'b0);
        expect_edge("next d0a", 4'b0001, 7'h30, 1'b0);

        // Asynchronous reset between edges while digit 0 is lit.
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async reset", 4'b0000, 7'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset held2", 4'b0000, 7'h00, 1'b0);
        rst_n = 1'b1;

        // Buffers cleared: every digit shows glyph 0.
        run_frame("post reset", 7'h7E, 7'h7E, 7'h7E, 7'h7E, -1, 20'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed 7-segment display driver: the sequential successor to the single-digit 5-bit-code-to-segment decoder. It scans `N_DIGITS` digits over a shared a–g segment bus, one digit per slot, with:
- double-buffered digit codes, so a frame never shows a mix of old and new values;
- dead-time between digits to suppress ghosting;
- selectable output polarity.

It sits between the datapath that produces per-digit 5-bit codes and the board display pins.

## Interface
- `N_DIGITS`, 4: number of scanned digits, 1–8.
- `SCAN_DIV`, 1000: clock cycles per digit slot, ≥2.
- `DEAD`, 1: cycles at the start of each slot with all digit selects off; 0 ≤ DEAD < SCAN_DIV.
- `ACTIVE_LOW`, 0: 1 inverts both `seg` and `dig_sel` at the pins.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: scan enable.
- `load` in 1: capture `codes` into the shadow buffer this cycle.
- `codes` in 5*N_DIGITS: digit k code at bits [5k+4:5k]; digit 0 is the least-significant field.
- `seg` out 7: {a,b,c,d,e,f,g}, with bit6 = a.
- `dig_sel` out N_DIGITS: one-hot digit select; bit k drives digit k.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- Glyph map, active-high logical values:
  - 0→7E, 1→30, 2→6D, 3→79, 4→33, 5→5B, 6→5F, 7→70, 8→7F, 9→7B.
  - A→77, b→1F, C→4E, d→3D, E→4F, F→47.
  - 0x10→00 (blank), 0x11→01 ('-'), 0x12–0x1F→00 (blank).
- Registers:
  - slot counter `cnt`: 0..SCAN_DIV-1, width clog2(SCAN_DIV).
  - digit index `idx`: 0..N_DIGITS-1, width max(1, clog2(N_DIGITS)).
  - shadow code buffer.
  - active code buffer.
- Counting (when `en`=1):
  - `cnt` increments every cycle.
  - At `cnt`=SCAN_DIV-1, `cnt` wraps to 0 and `idx` increments; `idx` wraps from N_DIGITS-1 to 0.
- Frame boundary is `cnt`=SCAN_DIV-1 and `idx`=N_DIGITS-1 with `en`=1. On that cycle:
  - active buffer ← shadow buffer;
  - `frame_done` is asserted on the next cycle.
- `load`=1 sets shadow ← `codes`, regardless of `en`.
  - If `load` coincides with a frame boundary, active takes the pre-load shadow value; the new codes display one frame later.
- Logical output, computed from the current `cnt`/`idx`/active buffer and registered:
  - `en`=0 or `cnt` < DEAD → `dig_sel`=0, `seg`=00.
  - Otherwise `dig_sel`=1<<idx and `seg`=glyph(active[idx]).
- `en`=0 holds `cnt`/`idx` frozen and blanks the outputs; re-enabling resumes from the held state.
- `ACTIVE_LOW`=1 inverts the registered `seg`/`dig_sel` values bitwise. `frame_done` is never inverted.

## Timing
- Reset (`rst_n`=0) takes effect immediately, without a clock edge:
  - `cnt`=0, `idx`=0, shadow=active=all-zero codes;
  - `seg`=00 (7F if ACTIVE_LOW), `dig_sel`=0 (all ones if ACTIVE_LOW), `frame_done`=0.
- Latency: outputs lag counter state by exactly one cycle.
  - First edge with `en`=1 after reset shows the `cnt`=0 state, i.e. dead-time.
  - Digit 0 is lit from the (DEAD+1)th edge.
- Each digit is lit for SCAN_DIV-DEAD cycles per slot, preceded by DEAD dark cycles.
- Frame period is N_DIGITS·SCAN_DIV enabled cycles. `frame_done` is high for exactly one cycle per frame.
- A new active buffer is first visible in slot 0 of the frame following the boundary. No frame ever mixes old and new codes.
- Reset asserted mid-frame:
  - outputs go to idle immediately;
  - buffers clear;
  - after release, scanning restarts at `idx`=0, `cnt`=0, displaying glyph 0 (7E) on all digits.
- `en` deasserted mid-slot: outputs go to idle on the next edge, and the remaining slot cycles are preserved.

## Test plan
Parameters N_DIGITS=4, SCAN_DIV=4, DEAD=1 unless noted.
- Reset:
  - stimulus: hold `rst_n`=0 with `clk` toggling, then assert `rst_n`=0 between edges mid-scan;
  - response: `seg`=00, `dig_sel`=0000, `frame_done`=0, asynchronously.
- Frame sequencing, first frame:
  - stimulus: after reset set `en`=1, then `load` with codes {3,2,1,0};
  - response: first frame shows 7E on every digit; `dig_sel` goes 0000,0001×3, 0000,0010×3, 0000,0100×3, 0000,1000×3;
  - `frame_done` pulses once every 16 cycles.
- Frame sequencing, after boundary:
  - stimulus: continue from the previous scenario past the next frame boundary;
  - response: digits 0–3 show 7E, 30, 6D, 79.
- Glyph extremes:
  - stimulus: codes {0x0A,0x1F,0x11,0x10} (digit3..digit0);
  - response: digit0=00, digit1=01, digit2=00, digit3=77.
- Buffering:
  - stimulus: `load` new codes during slot 2;
  - response: slots 2–3 keep the old glyphs; the new glyphs appear from slot 0 of the next frame.
  - stimulus: `load` on the boundary cycle itself;
  - response: the new glyphs appear one frame later.
- Enable pause:
  - stimulus: drop `en` for 5 cycles at `cnt`=2 of digit 1;
  - response: outputs idle during the pause and no `frame_done`; on resume, digit 1 is lit for 2 more cycles, then dead-time, then digit 2.
- Polarity:
  - stimulus: ACTIVE_LOW=1;
  - response: reset gives `seg`=7F, `dig_sel`=1111; digit 0 showing code 1 gives `seg`=4F, `dig_sel`=1110.
